// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared types and helpers for the sequential shift-add multiplier
package seq_mult_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } mult_state_t;

  function automatic bit cfg_ok(input int a_width, input int b_width, input int bpc);
    return (bpc == 1 || bpc == 2 || bpc == 4) && (a_width > 0) && (b_width > 0) &&
           (a_width % bpc == 0) && (a_width + b_width <= MAX_W);
  endfunction

  // Callers cast in and out of MAX_W; truncation keeps the result exact in the narrower width.
  function automatic logic [MAX_W-1:0] cond_negate(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mult_digit_step.sv
// rtl/mult_digit_step.sv - one radix step: add digit*|b| into the accumulator high half, then shift
module mult_digit_step #(
  parameter int A_WIDTH        = 8,
  parameter int B_WIDTH        = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [A_WIDTH+B_WIDTH-1:0] acc,
  input  logic [B_WIDTH-1:0]         b_mag,
  output logic [A_WIDTH+B_WIDTH-1:0] acc_next
);

  localparam int S_WIDTH = B_WIDTH + BITS_PER_CYCLE;

  logic [BITS_PER_CYCLE-1:0] digit;
  logic [S_WIDTH-1:0]        partial;
  logic [S_WIDTH-1:0]        sum;

  assign digit   = acc[BITS_PER_CYCLE-1:0];
  assign partial = S_WIDTH'(digit) * S_WIDTH'(b_mag);
  // High half plus digit*|b| is bounded by 2^BPC*(2^B-1), so S_WIDTH bits never overflow.
  assign sum      = S_WIDTH'(acc[A_WIDTH+B_WIDTH-1:A_WIDTH]) + partial;
  assign acc_next = (A_WIDTH+B_WIDTH)'({sum, acc[A_WIDTH-1:0]} >> BITS_PER_CYCLE);

endmodule

// File: rtl/seq_shift_add_mult.sv
// rtl/seq_shift_add_mult.sv - sequential shift-add multiplier with per-operand sign mode and handshakes
module seq_shift_add_mult
  import seq_mult_pkg::*;
#(
  parameter int A_WIDTH        = 8,
  parameter int B_WIDTH        = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  input  logic                       a_signed,
  input  logic                       b_signed,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [A_WIDTH+B_WIDTH-1:0] product,
  output logic                       busy
);

  localparam int N_ITER  = A_WIDTH / BITS_PER_CYCLE;
  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  localparam int CNT_W   = (N_ITER > 1) ? $clog2(N_ITER) : 1;

  if (!cfg_ok(A_WIDTH, B_WIDTH, BITS_PER_CYCLE)) begin : g_bad_cfg
    $fatal(1, "seq_shift_add_mult: illegal A_WIDTH/B_WIDTH/BITS_PER_CYCLE combination");
  end

  mult_state_t        state;
  logic [P_WIDTH-1:0] acc;
  logic [P_WIDTH-1:0] acc_next;
  logic [B_WIDTH-1:0] b_mag_q;
  logic               neg;
  logic [CNT_W-1:0]   iter;

  logic               a_neg;
  logic               b_neg;
  logic [A_WIDTH-1:0] a_mag;
  logic [B_WIDTH-1:0] b_mag;

  assign a_neg = a_signed & a[A_WIDTH-1];
  assign b_neg = b_signed & b[B_WIDTH-1];
  assign a_mag = A_WIDTH'(cond_negate(MAX_W'(a), a_neg));
  assign b_mag = B_WIDTH'(cond_negate(MAX_W'(b), b_neg));

  mult_digit_step #(
    .A_WIDTH       (A_WIDTH),
    .B_WIDTH       (B_WIDTH),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .acc     (acc),
    .b_mag   (b_mag_q),
    .acc_next(acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      product   <= '0;
      acc       <= '0;
      b_mag_q   <= '0;
      neg       <= 1'b0;
      iter      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Low half starts as |a|; retired multiplier bits shift out as the product shifts in.
            acc      <= P_WIDTH'(a_mag);
            b_mag_q  <= b_mag;
            neg      <= a_neg ^ b_neg;
            iter     <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          acc  <= acc_next;
          iter <= iter + CNT_W'(1);
          if (iter == CNT_W'(N_ITER - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          product   <= P_WIDTH'(cond_negate(MAX_W'(acc), neg));
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb/tb_seq_shift_add_mult.sv - self-checking bench for seq_shift_add_mult at radix 1, 2 and 4
module tb_seq_shift_add_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s[3];
  logic        in_valid_s[3];
  logic        in_ready_s[3];
  logic [7:0]  a_s[3];
  logic [7:0]  b_s[3];
  logic        a_signed_s[3];
  logic        b_signed_s[3];
  logic        out_valid_s[3];
  logic        out_ready_s[3];
  logic [15:0] product_s[3];
  logic        busy_s[3];

  int n_checks = 0;
  int n_pass   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    seq_shift_add_mult #(
      .A_WIDTH       (8),
      .B_WIDTH       (8),
      .BITS_PER_CYCLE(1 << g)
    ) u_dut (
      .clk      (clk),
      .rst      (rst_s[g]),
      .in_valid (in_valid_s[g]),
      .in_ready (in_ready_s[g]),
      .a        (a_s[g]),
      .b        (b_s[g]),
      .a_signed (a_signed_s[g]),
      .b_signed (b_signed_s[g]),
      .out_valid(out_valid_s[g]),
      .out_ready(out_ready_s[g]),
      .product  (product_s[g]),
      .busy     (busy_s[g])
    );
  end

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                          input logic as, input logic bs);
    longint ea;
    longint eb;
    ea = as ? longint'($signed(a)) : longint'(a);
    eb = bs ? longint'($signed(b)) : longint'(b);
    return 16'(ea * eb);
  endfunction

  // Issues one operation from IDLE; returns the product and edges from accept to out_valid.
  task automatic do_op(input int c, input logic [7:0] a, input logic [7:0] b,
                       input logic as, input logic bs,
                       output logic [15:0] p, output int lat);
    a_s[c] = a; b_s[c] = b; a_signed_s[c] = as; b_signed_s[c] = bs;
    in_valid_s[c] = 1'b1; out_ready_s[c] = 1'b0;
    @(posedge clk); #1;
    in_valid_s[c] = 1'b0; a_s[c] = ~a; b_s[c] = ~b;
    lat = 0;
    while (!out_valid_s[c] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    p = product_s[c];
    out_ready_s[c] = 1'b1;
    @(posedge clk); #1;
    out_ready_s[c] = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) rst_s[c] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) rst_s[c] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (in_ready_s[c] !== 1'b1) $display("FAIL reset_in_ready[%0d] got %b want 1", c, in_ready_s[c]);
      else n_pass++;
      n_checks++;
      if (out_valid_s[c] !== 1'b0) $display("FAIL reset_out_valid[%0d] got %b want 0", c, out_valid_s[c]);
      else n_pass++;
      n_checks++;
      if (product_s[c] !== 16'h0000) $display("FAIL reset_product[%0d] got %h want 0000", c, product_s[c]);
      else n_pass++;
      n_checks++;
      if (busy_s[c] !== 1'b0) $display("FAIL reset_busy[%0d] got %b want 0", c, busy_s[c]);
      else n_pass++;
    end
  endtask

  task automatic test_signed_min();
    logic [15:0] p;
    int lat;
    do_op(0, 8'h80, 8'h80, 1'b1, 1'b1, p, lat);
    n_checks++;
    if (p !== 16'h4000) $display("FAIL min_x_min product got %h want 4000", p);
    else n_pass++;
    n_checks++;
    if (lat !== 9) $display("FAIL min_x_min latency got %0d want 9", lat);
    else n_pass++;
  endtask

  task automatic test_mixed_sign();
    logic [15:0] p;
    int lat;
    do_op(0, 8'hFD, 8'd200, 1'b1, 1'b0, p, lat);
    n_checks++;
    if (p !== 16'hFDA8) $display("FAIL signed_x_unsigned product got %h want fda8", p);
    else n_pass++;
    do_op(0, 8'hFF, 8'hFF, 1'b0, 1'b0, p, lat);
    n_checks++;
    if (p !== 16'hFE01) $display("FAIL unsigned_max product got %h want fe01", p);
    else n_pass++;
  endtask

  task automatic test_radix2();
    logic [15:0] p;
    int lat;
    do_op(1, 8'd100, 8'hF9, 1'b1, 1'b1, p, lat);
    n_checks++;
    if (p !== 16'hFD44) $display("FAIL radix2_neg product got %h want fd44", p);
    else n_pass++;
    n_checks++;
    if (lat !== 5) $display("FAIL radix2 latency got %0d want 5", lat);
    else n_pass++;
    do_op(1, 8'h00, 8'h7F, 1'b1, 1'b1, p, lat);
    n_checks++;
    if (p !== 16'h0000) $display("FAIL radix2_zero product got %h want 0000", p);
    else n_pass++;
    n_checks++;
    if (lat !== 5) $display("FAIL radix2_zero latency got %0d want 5", lat);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int lat = 0;
    a_s[0] = 8'h37; b_s[0] = 8'h5A; a_signed_s[0] = 1'b0; b_signed_s[0] = 1'b0;
    in_valid_s[0] = 1'b1; out_ready_s[0] = 1'b0;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    while (!out_valid_s[0] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid_s[0] = (i == 2);
      a_s[0] = 8'h11; b_s[0] = 8'h22;
      @(posedge clk); #1;
      n_checks++;
      if (product_s[0] !== 16'h1356 || out_valid_s[0] !== 1'b1 || in_ready_s[0] !== 1'b0)
        $display("FAIL backpressure_hold[%0d] got p=%h ov=%b ir=%b want p=1356 ov=1 ir=0",
                 i, product_s[0], out_valid_s[0], in_ready_s[0]);
      else n_pass++;
    end
    in_valid_s[0] = 1'b1;
    out_ready_s[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    out_ready_s[0] = 1'b0;
    n_checks++;
    if (in_ready_s[0] !== 1'b1 || out_valid_s[0] !== 1'b0 || busy_s[0] !== 1'b0)
      $display("FAIL release_to_idle got ir=%b ov=%b busy=%b want ir=1 ov=0 busy=0",
               in_ready_s[0], out_valid_s[0], busy_s[0]);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (busy_s[0] !== 1'b0) $display("FAIL stale_accept busy got %b want 0", busy_s[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] p;
    int lat;
    a_s[0] = 8'hAB; b_s[0] = 8'hCD; a_signed_s[0] = 1'b0; b_signed_s[0] = 1'b0;
    in_valid_s[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (busy_s[0] !== 1'b1) $display("FAIL mid_run_busy got %b want 1", busy_s[0]);
    else n_pass++;
    rst_s[0] = 1'b1;
    @(posedge clk); #1;
    rst_s[0] = 1'b0;
    n_checks++;
    if (in_ready_s[0] !== 1'b1 || out_valid_s[0] !== 1'b0 || product_s[0] !== 16'h0000)
      $display("FAIL mid_run_reset got ir=%b ov=%b p=%h want ir=1 ov=0 p=0000",
               in_ready_s[0], out_valid_s[0], product_s[0]);
    else n_pass++;
    do_op(0, 8'd12, 8'd11, 1'b0, 1'b0, p, lat);
    n_checks++;
    if (p !== 16'd132) $display("FAIL after_reset_op product got %0d want 132", p);
    else n_pass++;
  endtask

  task automatic run_random(input int c, input int n_ops);
    int n_iter = 8 >> c;
    int cyc = 0;
    int last_acc = -1000;
    int sent = 0;
    int got = 0;
    logic [15:0] exp_q[$];
    logic        pre_ir;
    logic        pre_ov;
    logic [15:0] pre_p;
    logic [15:0] e;
    in_valid_s[c] = 1'b0;
    out_ready_s[c] = 1'b0;
    while (got < n_ops && cyc < 60000) begin
      if (!in_valid_s[c] && sent < n_ops && $urandom_range(0, 2) != 0) begin
        a_s[c] = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
        b_s[c] = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
        a_signed_s[c] = sent[0];
        b_signed_s[c] = sent[1];
        in_valid_s[c] = 1'b1;
      end
      out_ready_s[c] = ($urandom_range(0, 3) != 0);
      pre_ir = in_ready_s[c];
      pre_ov = out_valid_s[c];
      pre_p  = product_s[c];
      @(posedge clk); #1;
      cyc++;
      if (in_valid_s[c] && pre_ir) begin
        exp_q.push_back(ref_mul(a_s[c], b_s[c], a_signed_s[c], b_signed_s[c]));
        n_checks++;
        if (cyc - last_acc < n_iter + 3)
          $display("FAIL rand_ii[%0d] got %0d cycles want >= %0d", c, cyc - last_acc, n_iter + 3);
        else n_pass++;
        last_acc = cyc;
        sent++;
        in_valid_s[c] = 1'b0;
        a_s[c] = 8'($urandom);
        b_s[c] = 8'($urandom);
      end
      if (pre_ov && out_ready_s[c]) begin
        n_checks++;
        got++;
        if (exp_q.size() == 0) begin
          $display("FAIL rand_spurious[%0d] got product %h with nothing outstanding", c, pre_p);
        end else begin
          e = exp_q.pop_front();
          if (pre_p !== e) $display("FAIL rand_product[%0d] got %h want %h", c, pre_p, e);
          else n_pass++;
        end
      end
    end
    out_ready_s[c] = 1'b0;
    n_checks++;
    if (got !== n_ops) $display("FAIL rand_timeout[%0d] got %0d results want %0d", c, got, n_ops);
    else n_pass++;
  endtask

  initial begin
    for (int c = 0; c < 3; c++) begin
      rst_s[c] = 1'b1; in_valid_s[c] = 1'b0; out_ready_s[c] = 1'b0;
      a_s[c] = '0; b_s[c] = '0; a_signed_s[c] = 1'b0; b_signed_s[c] = 1'b0;
    end
    test_reset();
    test_signed_min();
    test_mixed_sign();
    test_radix2();
    test_backpressure();
    test_reset_mid_run();
    fork
      run_random(0, 1500);
      run_random(1, 1500);
      run_random(2, 1500);
    join
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
